// File: rtl/sample_feeder.sv
// Streams one block of samples out of a synchronous sample memory at a fixed
// read pace, with backpressure, abort, and a running count of completed blocks.
module sample_feeder #(
    parameter int WIDTH      = 3,
    parameter int BLOCK_LEN  = 16368,
    parameter int ADDR_WIDTH = 14,
    parameter int PACE       = 1
) (
    input  logic                  clk,
    input  logic                  global_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  hold,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_data,
    output logic                  feed_reset,
    output logic                  data_available,
    output logic [WIDTH-1:0]      data,
    output logic                  feed_complete,
    output logic                  busy,
    output logic [15:0]           block_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(BLOCK_LEN - 1);
    localparam logic [7:0]            PACE_RELOAD = 8'(PACE - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              pace_q, pace_d;
    logic                    avail_q;
    logic [WIDTH-1:0]        data_q;
    logic [15:0]             count_q;
    logic                    rd_s;

    // A read issues only when the pace window is open and the consumer is not stalling.
    assign rd_s = (state_q == S_FEED) && (pace_q == 8'd0) && !hold;

    // Next-state, address and pace-counter logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pace_d  = pace_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RESET;
                end else begin
                    state_d = S_IDLE;
                end
                addr_d = '0;
                pace_d = 8'd0;
            end
            S_RESET: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FEED;
                end
                addr_d = '0;
                pace_d = 8'd0;
            end
            S_FEED: begin
                if (rd_s) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    pace_d = PACE_RELOAD;
                end else if (pace_q != 8'd0) begin
                    pace_d = pace_q - 8'd1;
                end else begin
                    pace_d = pace_q;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rd_s && (addr_q == LAST_ADDR)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FEED;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, strobe and counter registers; reset discards any in-flight read.
    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pace_q  <= 8'd0;
            avail_q <= 1'b0;
            data_q  <= '0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pace_q  <= pace_d;
            avail_q <= rd_s;
            if (avail_q) begin
                data_q <= mem_data;
            end
            if (state_q == S_DONE) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    // The memory returns data one cycle after the strobe, so the sample is
    // forwarded in its arrival cycle and captured for holding afterwards.
    assign data           = avail_q ? mem_data : data_q;
    assign data_available = avail_q;
    assign mem_rd         = rd_s;
    assign mem_addr       = addr_q;
    assign feed_reset     = (state_q == S_RESET);
    assign feed_complete  = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);
    assign block_count    = count_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: a PACE=1 and a PACE=3 instance with
// BLOCK_LEN=4 read a small memory holding 1,2,3,4.
module tb_sample_feeder;

    logic        clk = 1'b0;
    logic        global_reset, start, start3, abort, hold, sel;
    logic        rd1, fr1, da1, fc1, busy1;
    logic        rd3, fr3, da3, fc3, busy3;
    logic [1:0]  addr1, addr3;
    logic [2:0]  mem_data1, mem_data3, data1, data3;
    logic [15:0] bc1, bc3;
    logic [2:0]  mem [4];
    logic [4:0]  obs_flags;
    logic [1:0]  obs_addr;
    logic [2:0]  obs_data;
    logic [15:0] obs_bc;
    int          n_cmp = 0;
    int          n_err = 0;

    // flag vectors: {feed_reset, mem_rd, data_available, feed_complete, busy}
    localparam logic [4:0] IDL = 5'b00000;
    localparam logic [4:0] FR  = 5'b10001;
    localparam logic [4:0] RD  = 5'b01001;
    localparam logic [4:0] RDA = 5'b01101;
    localparam logic [4:0] DA  = 5'b00101;
    localparam logic [4:0] FC  = 5'b00011;
    localparam logic [4:0] BZ  = 5'b00001;
    localparam logic [4:0] DAI = 5'b00100;

    always #5 clk = ~clk;

    sample_feeder #(.WIDTH(3), .BLOCK_LEN(4), .ADDR_WIDTH(2), .PACE(1)) dut1 (
        .clk(clk), .global_reset(global_reset), .start(start), .abort(abort), .hold(hold),
        .mem_rd(rd1), .mem_addr(addr1), .mem_data(mem_data1), .feed_reset(fr1),
        .data_available(da1), .data(data1), .feed_complete(fc1), .busy(busy1),
        .block_count(bc1)
    );

    sample_feeder #(.WIDTH(3), .BLOCK_LEN(4), .ADDR_WIDTH(2), .PACE(3)) dut3 (
        .clk(clk), .global_reset(global_reset), .start(start3), .abort(abort), .hold(hold),
        .mem_rd(rd3), .mem_addr(addr3), .mem_data(mem_data3), .feed_reset(fr3),
        .data_available(da3), .data(data3), .feed_complete(fc3), .busy(busy3),
        .block_count(bc3)
    );

    // Synchronous memory model; returns junk when not read so held data is exercised.
    always @(posedge clk) begin
        mem_data1 <= rd1 ? mem[addr1] : 3'd7;
        mem_data3 <= rd3 ? mem[addr3] : 3'd7;
    end

    assign obs_flags = sel ? {fr3, rd3, da3, fc3, busy3} : {fr1, rd1, da1, fc1, busy1};
    assign obs_addr  = sel ? addr3 : addr1;
    assign obs_data  = sel ? data3 : data1;
    assign obs_bc    = sel ? bc3 : bc1;

    task automatic run_cycle(input logic rst, input logic st, input logic ab, input logic hd,
                             input logic [4:0] ef, input logic [1:0] ea, input logic [2:0] ed,
                             input logic [15:0] eb, input string tag, input int cyc);
        global_reset = rst;
        start        = st & ~sel;
        start3       = st & sel;
        abort        = ab;
        hold         = hd;
        @(negedge clk);
        n_cmp++;
        assert (obs_flags === ef) else begin
            n_err++;
            $error("FAIL %s c%0d flags observed=%b expected=%b", tag, cyc, obs_flags, ef);
        end
        n_cmp++;
        assert (obs_data === ed) else begin
            n_err++;
            $error("FAIL %s c%0d data observed=%0d expected=%0d", tag, cyc, obs_data, ed);
        end
        n_cmp++;
        assert (obs_bc === eb) else begin
            n_err++;
            $error("FAIL %s c%0d block_count observed=%h expected=%h", tag, cyc, obs_bc, eb);
        end
        if (ef[3]) begin
            n_cmp++;
            assert (obs_addr === ea) else begin
                n_err++;
                $error("FAIL %s c%0d mem_addr observed=%0d expected=%0d", tag, cyc, obs_addr, ea);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[0] = 3'd1; mem[1] = 3'd2; mem[2] = 3'd3; mem[3] = 3'd4;
        sel = 1'b0; global_reset = 1'b1; start = 1'b0; start3 = 1'b0;
        abort = 1'b0; hold = 1'b0;
        @(posedge clk);
        #1;
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd0, 16'd0, "reset", 0);
        n_cmp++;
        assert (addr1 === 2'd0) else begin
            n_err++;
            $error("FAIL reset mem_addr observed=%0d expected=0", addr1);
        end

        // basic block, abort during DONE is ignored
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd0, 16'd0, "basic", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd0, 16'd0, "basic", 1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd0, 16'd0, "basic", 2);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd1, 3'd1, 16'd0, "basic", 3);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd2, 3'd2, 16'd0, "basic", 4);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd3, 3'd3, 16'd0, "basic", 5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd4, 16'd0, "basic", 6);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, FC,  2'd0, 3'd4, 16'd0, "basic", 7);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd1, "basic", 8);

        // start together with abort in IDLE is ignored
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0, IDL, 2'd0, 3'd4, 16'd1, "stab", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd1, "stab", 1);

        // hold during cycles 3-5, start during DONE is ignored
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd1, "hold", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd4, 16'd1, "hold", 1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd4, 16'd1, "hold", 2);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, DA,  2'd0, 3'd1, 16'd1, "hold", 3);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, BZ,  2'd0, 3'd1, 16'd1, "hold", 4);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, BZ,  2'd0, 3'd1, 16'd1, "hold", 5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd1, 3'd1, 16'd1, "hold", 6);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd2, 3'd2, 16'd1, "hold", 7);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd3, 3'd3, 16'd1, "hold", 8);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd4, 16'd1, "hold", 9);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, FC,  2'd0, 3'd4, 16'd1, "hold", 10);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd2, "hold", 11);

        // abort at cycle 4: in-flight read still delivered, no completion
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd2, "abort", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd4, 16'd2, "abort", 1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd4, 16'd2, "abort", 2);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd1, 3'd1, 16'd2, "abort", 3);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, RDA, 2'd2, 3'd2, 16'd2, "abort", 4);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DAI, 2'd0, 3'd3, 16'd2, "abort", 5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd3, 16'd2, "abort", 6);

        // restart after abort feeds from address 0
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd3, 16'd2, "rest", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd3, 16'd2, "rest", 1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd3, 16'd2, "rest", 2);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd1, 3'd1, 16'd2, "rest", 3);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd2, 3'd2, 16'd2, "rest", 4);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd3, 3'd3, 16'd2, "rest", 5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd4, 16'd2, "rest", 6);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FC,  2'd0, 3'd4, 16'd2, "rest", 7);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd3, "rest", 8);

        // global_reset at cycle 4 of a block
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd3, "grst", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd4, 16'd3, "grst", 1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd4, 16'd3, "grst", 2);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd1, 3'd1, 16'd3, "grst", 3);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, RDA, 2'd2, 3'd2, 16'd3, "grst", 4);
        n_cmp++;
        assert (addr1 === 2'd0) else begin
            n_err++;
            $error("FAIL grst c5 mem_addr observed=%0d expected=0", addr1);
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd0, 16'd0, "grst", 5);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd0, 16'd0, "grst", 6);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd0, 16'd0, "grst", 7);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd0, 16'd0, "grst", 8);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd1, 3'd1, 16'd0, "grst", 9);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd2, 3'd2, 16'd0, "grst", 10);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd3, 3'd3, 16'd0, "grst", 11);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd4, 16'd0, "grst", 12);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FC,  2'd0, 3'd4, 16'd0, "grst", 13);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd1, "grst", 14);

        // PACE=3 instance: reads at 2,5,8,11, completion at 13
        sel = 1'b1;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd0, 16'd0, "pace3", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd0, 16'd0, "pace3", 1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd0, 16'd0, "pace3", 2);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd1, 16'd0, "pace3", 3);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, BZ,  2'd0, 3'd1, 16'd0, "pace3", 4);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd1, 3'd1, 16'd0, "pace3", 5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd2, 16'd0, "pace3", 6);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, BZ,  2'd0, 3'd2, 16'd0, "pace3", 7);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd2, 3'd2, 16'd0, "pace3", 8);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd3, 16'd0, "pace3", 9);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, BZ,  2'd0, 3'd3, 16'd0, "pace3", 10);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd3, 3'd3, 16'd0, "pace3", 11);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd4, 16'd0, "pace3", 12);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FC,  2'd0, 3'd4, 16'd0, "pace3", 13);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'd1, "pace3", 14);

        // block_count wrap from 0xFFFF
        sel = 1'b0;
        force dut1.count_q = 16'hFFFF;
        #1;
        release dut1.count_q;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'hFFFF, "wrap", 0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FR,  2'd0, 3'd4, 16'hFFFF, "wrap", 1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RD,  2'd0, 3'd4, 16'hFFFF, "wrap", 2);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd1, 3'd1, 16'hFFFF, "wrap", 3);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd2, 3'd2, 16'hFFFF, "wrap", 4);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, RDA, 2'd3, 3'd3, 16'hFFFF, "wrap", 5);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, DA,  2'd0, 3'd4, 16'hFFFF, "wrap", 6);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, FC,  2'd0, 3'd4, 16'hFFFF, "wrap", 7);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, IDL, 2'd0, 3'd4, 16'h0000, "wrap", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter WIDTH, default 3, sample width in bits (matches channel data input).
REQ-002 Parameter BLOCK_LEN, default 16368, samples per feed block (1 ms at 16.368 MHz).
REQ-003 Parameter ADDR_WIDTH, default 14, sample memory address width; SHALL satisfy 2^ADDR_WIDTH >= BLOCK_LEN.
REQ-004 Parameter PACE, default 1, cycles between successive sample reads; legal range 1..255.
REQ-005 Port clk, input, 1, single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port global_reset, input, 1, synchronous active-high reset.
REQ-007 Port start, input, 1, one-cycle request to feed one block; honoured only in IDLE.
REQ-008 Port abort, input, 1, terminates the block in progress without feed_complete.
REQ-009 Port hold, input, 1, backpressure; while high no new read is issued.
REQ-010 Port mem_rd, output, 1, sample memory read strobe.
REQ-011 Port mem_addr, output, ADDR_WIDTH, read address, valid while mem_rd high.
REQ-012 Port mem_data, input, WIDTH, read data, valid exactly 1 cycle after mem_rd.
REQ-013 Port feed_reset, output, 1, one-cycle pulse marking block start.
REQ-014 Port data_available, output, 1, one-cycle strobe qualifying data.
REQ-015 Port data, output, WIDTH, registered sample.
REQ-016 Port feed_complete, output, 1, one-cycle pulse after the last sample of a block.
REQ-017 Port busy, output, 1, high in every state except IDLE.
REQ-018 Port block_count, output, 16, count of completed blocks; wraps 0xFFFF->0x0000.

Function
REQ-019 FSM states SHALL be IDLE, RESET, FEED, DRAIN, DONE.
REQ-020 IDLE->RESET on start; RESET SHALL last one cycle with feed_reset=1, then go to FEED.
REQ-021 On entering FEED the address counter SHALL be 0 and the pace counter SHALL be 0.
REQ-022 In FEED, when pace counter==0 and hold==0, the block SHALL assert mem_rd with mem_addr=address counter, increment the address, and reload the pace counter with PACE-1; otherwise the nonzero pace counter SHALL decrement, including while hold is high.
REQ-023 The cycle after each mem_rd, data_available SHALL be 1 and data SHALL equal mem_data (latency start->first data_available = 3 cycles).
REQ-024 The read at address BLOCK_LEN-1 SHALL move the FSM to DRAIN; DRAIN SHALL last one cycle, in which the final data_available is emitted.
REQ-025 DONE SHALL last one cycle: feed_complete=1, block_count increments, then IDLE.
REQ-026 feed_reset, data_available, feed_complete SHALL be mutually exclusive in every cycle.
REQ-027 start while busy SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-028 abort in RESET, FEED, or DRAIN SHALL go to IDLE next cycle; an in-flight read (mem_rd in the abort cycle) SHALL still produce its data_available; no feed_complete is issued and block_count is unchanged.
REQ-029 abort in DONE SHALL be ignored (feed_complete still issued).
REQ-030 With PACE=1 and hold low, mem_rd SHALL be asserted on BLOCK_LEN consecutive cycles.
REQ-031 data SHALL hold its last value when data_available is 0.

Reset
REQ-032 global_reset SHALL take priority over all inputs, in any state.
REQ-033 After reset: state IDLE; mem_rd, feed_reset, data_available, feed_complete, busy = 0; mem_addr, data, block_count = 0; in-flight read discarded (no data_available the cycle after reset).

Verification
REQ-034 BLOCK_LEN=4, PACE=1, memory = 1,2,3,4; start at cycle 0 -> feed_reset at 1, mem_rd at 2-5 addrs 0-3, data_available at 3-6 with data 1,2,3,4, feed_complete at 7, block_count=1, busy low at 8.
REQ-035 BLOCK_LEN=4, PACE=3; start at 0 -> mem_rd at cycles 2,5,8,11; feed_complete at 13.
REQ-036 PACE=1, hold high during cycles 3-5 -> no mem_rd at 3-5; reads resume at 6 with addr 1; all 4 samples delivered in order; feed_complete at 10.
REQ-037 abort at cycle 4 (PACE=1) -> data_available at 5 for addr 2, busy=0 from 5, no feed_complete, block_count unchanged; next start feeds from addr 0.
REQ-038 global_reset asserted at cycle 4 of a block -> all outputs 0 at cycle 5, no data_available at 5; start at 6 gives feed_reset at 7.
REQ-039 block_count preloaded by 65535 completed blocks (or forced) -> next feed_complete wraps it to 0.
